// File: rtl/amp_to_phase_detector.sv
// Recovers timing from a DDS amplitude stream: hysteresis comparator, rising-crossing
// period measurement, running phase index and period-stability lock.
module amp_to_phase_detector #(
  parameter int MID      = 200,
  parameter int HYST     = 8,
  parameter int CNT_W    = 16,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [8:0]       sample,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             level_high,
  output logic             locked,
  output logic             overflow
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [9:0]       HI_TH   = 10'(MID + HYST);
  localparam logic [9:0]       LO_TH   = 10'(MID - HYST);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(LOCK_TOL);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  typedef enum logic [1:0] {ST_UNKNOWN, ST_LOW, ST_HIGH} state_t;

  state_t           state_reg, state_next;
  logic             armed;
  logic [MW-1:0]    match_cnt;
  logic [CNT_W-1:0] prev_period;

  logic [9:0]       sample_ext;
  logic             at_high, at_low;
  logic             rise_event;
  logic             phase_sat;
  logic [CNT_W-1:0] period_new;
  logic [CNT_W:0]   period_ext, prev_ext, delta;
  logic             in_tol;
  logic [MW-1:0]    match_inc;

  assign sample_ext = {1'b0, sample};
  assign at_high    = (sample_ext >= HI_TH);
  assign at_low     = (sample_ext <= LO_TH);

  // Comparator FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state_reg <= ST_UNKNOWN;
    else if (clear)  state_reg <= ST_UNKNOWN;
    else             state_reg <= state_next;
  end

  // Comparator FSM: next state
  always_comb begin
    state_next = state_reg;
    if (sample_valid) begin
      case (state_reg)
        ST_UNKNOWN: begin
          if (at_high)     state_next = ST_HIGH;
          else if (at_low) state_next = ST_LOW;
        end
        ST_LOW:  if (at_high) state_next = ST_HIGH;
        ST_HIGH: if (at_low)  state_next = ST_LOW;
        default: state_next = ST_UNKNOWN;
      endcase
    end
  end

  // Comparator FSM: outputs; only LOW -> HIGH counts as a crossing
  always_comb begin
    level_high = (state_reg == ST_HIGH);
    rise_event = sample_valid && (state_reg == ST_LOW) && at_high;
  end

  assign phase_sat  = (phase_cnt == CNT_MAX);
  assign period_new = phase_cnt + CNT_ONE;
  assign period_ext = {1'b0, period_new};
  assign prev_ext   = {1'b0, prev_period};
  assign delta      = (period_ext >= prev_ext) ? (period_ext - prev_ext) : (prev_ext - period_ext);
  assign in_tol     = (delta <= TOL_V);
  assign match_inc  = (match_cnt == LOCK_V) ? match_cnt : (match_cnt + MATCH_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
      armed        <= 1'b0;
      match_cnt    <= '0;
      prev_period  <= '0;
    end else if (clear) begin
      phase_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
      armed        <= 1'b0;
      match_cnt    <= '0;
      prev_period  <= '0;
    end else begin
      period_valid <= 1'b0;
      if (sample_valid) begin
        if (rise_event) begin
          phase_cnt <= '0;
          if (!armed) begin
            armed <= 1'b1;
          end else if (phase_sat) begin
            overflow  <= 1'b1;
            match_cnt <= '0;
            locked    <= 1'b0;
          end else begin
            period       <= period_new;
            period_valid <= 1'b1;
            prev_period  <= period_new;
            // prev_period is never 0 once a period has been measured
            if (prev_period != '0) begin
              if (in_tol) begin
                match_cnt <= match_inc;
                locked    <= (match_inc == LOCK_V);
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end
          end
        end else if (!phase_sat) begin
          phase_cnt <= phase_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_amp_to_phase_detector.sv
// Directed checks of amp_to_phase_detector: reset, square wave lock, jitter, gaps/clear,
// noise rejection and counter overflow on a narrow-counter instance.
module tb_amp_to_phase_detector;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        sample_valid;
  logic [8:0]  sample;

  logic [15:0] phase_cnt, period;
  logic        period_valid, level_high, locked, overflow;
  logic [7:0]  s_phase_cnt, s_period;
  logic        s_period_valid, s_level_high, s_locked, s_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_seen  = 0;

  amp_to_phase_detector u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid), .sample(sample),
    .phase_cnt(phase_cnt), .period(period), .period_valid(period_valid),
    .level_high(level_high), .locked(locked), .overflow(overflow)
  );

  amp_to_phase_detector #(.CNT_W(8)) u_small (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid), .sample(sample),
    .phase_cnt(s_phase_cnt), .period(s_period), .period_valid(s_period_valid),
    .level_high(s_level_high), .locked(s_locked), .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_phase"},  32'(phase_cnt),    0);
    chk({tag, "_period"}, 32'(period),       0);
    chk({tag, "_pv"},     32'(period_valid), 0);
    chk({tag, "_lh"},     32'(level_high),   0);
    chk({tag, "_locked"}, 32'(locked),       0);
    chk({tag, "_ovf"},    32'(overflow),     0);
  endtask

  task automatic step(input logic v, input logic [8:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
    if (period_valid) pv_seen++;
  endtask

  // hi_n high samples then lo_n low samples; gap inserts an invalid cycle after each
  task automatic rest(input int hi_n, input int lo_n, input logic gap);
    for (int i = 0; i < hi_n; i++) begin
      step(1'b1, 9'd300);
      if (gap) step(1'b0, 9'd100);
    end
    for (int i = 0; i < lo_n; i++) begin
      step(1'b1, 9'd100);
      if (gap) step(1'b0, 9'd300);
    end
  endtask

  initial begin
    int pv_before;
    int lh_high_cnt;
    rst_n        = 1'b0;
    clear        = 1'b0;
    sample_valid = 1'b0;
    sample       = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    rst_n = 1'b1;
    repeat (5) step(1'b0, 9'd300);
    chk_zero("idle");

    // Square wave: first block leaves UNKNOWN, not a crossing
    step(1'b1, 9'd300);
    chk("enter_high_lh", 32'(level_high), 1);
    rest(99, 100, 1'b0);
    chk("first_low_lh", 32'(level_high), 0);
    chk("first_low_phase", 32'(phase_cnt), 200);
    step(1'b1, 9'd300);
    chk("cross1_pv", 32'(period_valid), 0);
    chk("cross1_phase", 32'(phase_cnt), 0);
    rest(99, 100, 1'b0);
    chk("ramp_top", 32'(phase_cnt), 199);
    chk("cross1_no_pulse", 32'(pv_seen), 0);
    step(1'b1, 9'd300);
    chk("cross2_pv", 32'(period_valid), 1);
    chk("cross2_period", 32'(period), 200);
    chk("cross2_locked", 32'(locked), 0);
    step(1'b1, 9'd300);
    chk("cross2_pv_drop", 32'(period_valid), 0);
    chk("cross2_period_hold", 32'(period), 200);
    rest(98, 100, 1'b0);
    for (int k = 3; k <= 6; k++) begin
      step(1'b1, 9'd300);
      chk("sq_pv", 32'(period_valid), 1);
      chk("sq_period", 32'(period), 200);
      chk("sq_locked", 32'(locked), (k == 6) ? 1 : 0);
      rest(99, 100, 1'b0);
    end
    chk("sq_pulses", 32'(pv_seen), 5);

    // Jitter: 200 keeps lock, then 203 (delta 3) drops it in the pulse cycle
    step(1'b1, 9'd300);
    chk("jit_keep_locked", 32'(locked), 1);
    rest(99, 103, 1'b0);
    step(1'b1, 9'd300);
    chk("jit_pv", 32'(period_valid), 1);
    chk("jit_period", 32'(period), 203);
    chk("jit_unlock", 32'(locked), 0);
    rest(99, 100, 1'b0);
    step(1'b1, 9'd300);
    chk("jit_back_period", 32'(period), 200);
    chk("jit_back_locked", 32'(locked), 0);
    rest(99, 100, 1'b0);

    // Gapped valid: period still counts only valid samples
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 9'd300);
      chk("gap_pv", 32'(period_valid), 1);
      chk("gap_period", 32'(period), 200);
      chk("gap_locked", 32'(locked), (k == 4) ? 1 : 0);
      step(1'b0, 9'd100);
      chk("gap_pv_drop", 32'(period_valid), 0);
      rest((k == 4) ? 50 : 99, (k == 4) ? 0 : 100, 1'b1);
    end
    chk("gap_mid_phase", 32'(phase_cnt), 50);

    // Clear mid-period with a valid sample that must be ignored
    clear        = 1'b1;
    sample_valid = 1'b1;
    sample       = 9'd100;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk_zero("clear");

    // Noise inside the hysteresis band after entering LOW
    step(1'b1, 9'd100);
    chk("noise_enter_phase", 32'(phase_cnt), 1);
    pv_before   = pv_seen;
    lh_high_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, (i % 2 == 0) ? 9'd193 : 9'd207);
      if (level_high) lh_high_cnt++;
    end
    chk("noise_lh_cnt", 32'(lh_high_cnt), 0);
    chk("noise_pulses", 32'(pv_seen - pv_before), 0);
    chk("noise_phase", 32'(phase_cnt), 501);

    // First crossing after clear only arms; the next one measures
    step(1'b1, 9'd300);
    chk("rearm_pv", 32'(period_valid), 0);
    chk("rearm_period", 32'(period), 0);
    chk("rearm_phase", 32'(phase_cnt), 0);
    rest(99, 100, 1'b0);
    step(1'b1, 9'd300);
    chk("rearm2_pv", 32'(period_valid), 1);
    chk("rearm2_period", 32'(period), 200);
    chk("small_period", 32'(s_period), 200);
    chk("small_pv", 32'(s_period_valid), 1);

    // Overflow on the 8-bit instance: 399 samples between crossings saturates it
    rest(99, 300, 1'b0);
    chk("small_sat_phase", 32'(s_phase_cnt), 255);
    chk("big_phase", 32'(phase_cnt), 399);
    step(1'b1, 9'd300);
    chk("small_ovf", 32'(s_overflow), 1);
    chk("small_ovf_pv", 32'(s_period_valid), 0);
    chk("small_ovf_period", 32'(s_period), 200);
    chk("small_ovf_locked", 32'(s_locked), 0);
    chk("small_ovf_phase", 32'(s_phase_cnt), 0);
    chk("big_long_pv", 32'(period_valid), 1);
    chk("big_long_period", 32'(period), 400);
    chk("big_no_ovf", 32'(overflow), 0);
    rest(10, 0, 1'b0);
    chk("small_ovf_sticky", 32'(s_overflow), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
